// File: rtl/avalon_st_pkt_arbiter.sv
// rtl/avalon_st_pkt_arbiter.sv - packet-locked round-robin arbiter for Avalon-ST sources
module avalon_st_pkt_arbiter #(
    parameter int WIDTH       = 64,
    parameter int EMPTY_WIDTH = $clog2(WIDTH / 8),
    parameter int NUM_IN      = 4,
    parameter int SEL_W       = $clog2(NUM_IN)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_IN-1:0][WIDTH-1:0]          in_data,
    input  logic [NUM_IN-1:0]                     in_valid,
    output logic [NUM_IN-1:0]                     in_ready,
    input  logic [NUM_IN-1:0]                     in_sop,
    input  logic [NUM_IN-1:0]                     in_eop,
    input  logic [NUM_IN-1:0][EMPTY_WIDTH-1:0]    in_empty,
    output logic [WIDTH-1:0]                      out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_sop,
    output logic                                  out_eop,
    output logic [EMPTY_WIDTH-1:0]                out_empty,
    output logic [SEL_W-1:0]                      out_channel,
    output logic                                  busy,
    output logic [NUM_IN-1:0][15:0]               pkt_count,
    output logic [NUM_IN-1:0]                     err_sop
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                    state_q;
    logic [SEL_W-1:0]          grant_q;
    logic [SEL_W-1:0]          rr_ptr_q;
    logic                      first_beat_q;
    logic [NUM_IN-1:0][15:0]   pkt_count_q;
    logic [NUM_IN-1:0]         err_sop_q;

    logic [NUM_IN-1:0]         req;
    logic [SEL_W-1:0]          idx;
    logic [SEL_W-1:0]          grant_d;
    logic                      found_d;
    logic                      locked;
    logic                      xfer;

    // First requester at or after rr_ptr, wrapping modulo NUM_IN.
    always_comb begin
        req     = in_valid & in_sop;
        grant_d = '0;
        found_d = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = SEL_W'((int'(rr_ptr_q) + k) % NUM_IN);
            if (!found_d && req[idx]) begin
                found_d = 1'b1;
                grant_d = idx;
            end
        end
    end

    assign locked      = (state_q == LOCKED);
    assign out_data    = in_data[grant_q];
    assign out_empty   = in_empty[grant_q];
    assign out_valid   = locked & in_valid[grant_q];
    assign out_sop     = locked & in_sop[grant_q];
    assign out_eop     = locked & in_eop[grant_q];
    assign out_channel = grant_q;
    assign busy        = locked;
    assign pkt_count   = pkt_count_q;
    assign err_sop     = err_sop_q;
    assign xfer        = out_valid & out_ready;

    always_comb begin
        in_ready = '0;
        if (locked) begin
            in_ready[grant_q] = out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            first_beat_q <= 1'b0;
            pkt_count_q  <= '0;
            err_sop_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q      <= grant_d;
                        first_beat_q <= 1'b1;
                        state_q      <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        first_beat_q <= 1'b0;
                        // A fresh SOP inside a locked packet is flagged but still forwarded.
                        if (in_sop[grant_q] && !first_beat_q) begin
                            err_sop_q[grant_q] <= 1'b1;
                        end
                        if (in_eop[grant_q]) begin
                            state_q               <= IDLE;
                            rr_ptr_q              <= (grant_q == SEL_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
                            pkt_count_q[grant_q]  <= pkt_count_q[grant_q] + 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// tb/tb_avalon_st_pkt_arbiter.sv - directed self-checking bench for avalon_st_pkt_arbiter
module tb_avalon_st_pkt_arbiter;

    localparam int W  = 64;
    localparam int EW = 3;
    localparam int N  = 4;
    localparam int SW = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0][W-1:0]    in_data;
    logic [N-1:0]           in_valid;
    logic [N-1:0]           in_ready;
    logic [N-1:0]           in_sop;
    logic [N-1:0]           in_eop;
    logic [N-1:0][EW-1:0]   in_empty;
    logic [W-1:0]           out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_sop;
    logic                   out_eop;
    logic [EW-1:0]          out_empty;
    logic [SW-1:0]          out_channel;
    logic                   busy;
    logic [N-1:0][15:0]     pkt_count;
    logic [N-1:0]           err_sop;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avalon_st_pkt_arbiter #(
        .WIDTH(W), .EMPTY_WIDTH(EW), .NUM_IN(N), .SEL_W(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .out_channel(out_channel), .busy(busy),
        .pkt_count(pkt_count), .err_sop(err_sop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int b;
    int cyc;
    int pkts;

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        in_sop    = '0;
        in_eop    = '0;
        in_empty  = '0;
        out_ready = 1'b0;

        do_reset();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_channel", out_channel, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_err_sop", err_sop, 0);

        // Single port: port 2 sends A1, A2, A3
        in_valid[2] = 1'b1; in_sop[2] = 1'b1; in_data[2] = 64'hA1; out_ready = 1'b1;
        #1;
        chk("sp_arb_valid", out_valid, 0);
        chk("sp_arb_ready", in_ready, 0);
        tick();
        chk("sp_b1_valid", out_valid, 1);
        chk("sp_b1_chan", out_channel, 2);
        chk("sp_b1_data", out_data, 64'hA1);
        chk("sp_b1_ready", in_ready, 4'b0100);
        chk("sp_b1_busy", busy, 1);
        tick();
        in_sop[2] = 1'b0; in_data[2] = 64'hA2;
        #1;
        chk("sp_b2_data", out_data, 64'hA2);
        chk("sp_b2_valid", out_valid, 1);
        tick();
        in_eop[2] = 1'b1; in_data[2] = 64'hA3; in_empty[2] = 3'd5;
        #1;
        chk("sp_b3_data", out_data, 64'hA3);
        chk("sp_b3_eop", out_eop, 1);
        chk("sp_b3_empty", out_empty, 5);
        tick();
        in_valid[2] = 1'b0; in_eop[2] = 1'b0; in_empty[2] = '0;
        #1;
        chk("sp_idle_busy", busy, 0);
        chk("sp_idle_valid", out_valid, 0);
        chk("sp_idle_chan", out_channel, 2);
        chk("sp_count", pkt_count[2], 1);

        // Round-robin: all ports offer single-beat packets from reset
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b1; in_sop[i] = 1'b1; in_eop[i] = 1'b1;
            in_data[i]  = 64'h100 + 64'(i);
        end
        pkts = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk("rr_valid", out_valid, 64'(c % 2));
            if (c % 2 == 1) begin
                chk("rr_chan", out_channel, 64'((c / 2) % 4));
                chk("rr_data", out_data, 64'h100 + 64'((c / 2) % 4));
            end
            if (out_valid && out_ready) pkts++;
            tick();
        end
        chk("rr_pkts", pkts, 8);
        chk("rr_counts", pkt_count, {16'd2, 16'd2, 16'd2, 16'd2});
        in_valid = '0; in_sop = '0; in_eop = '0;
        tick();

        // No interleave with backpressure: port 1 locked, port 0 waits
        in_valid[1] = 1'b1; in_sop[1] = 1'b1; in_data[1] = 64'hC1;
        #1;
        chk("ni_arb_valid", out_valid, 0);
        tick();
        in_valid[0] = 1'b1; in_sop[0] = 1'b1; in_eop[0] = 1'b1; in_data[0] = 64'hB0;
        b = 0;
        cyc = 0;
        while (b < 4 && cyc < 16) begin
            in_data[1] = 64'hC1 + 64'(b);
            in_sop[1]  = (b == 0);
            in_eop[1]  = (b == 3);
            out_ready  = (cyc % 2 == 0);
            #1;
            chk("ni_chan", out_channel, 1);
            chk("ni_data", out_data, 64'hC1 + 64'(b));
            chk("ni_in_ready", in_ready, out_ready ? 4'b0010 : 4'b0000);
            tick();
            if (out_ready) b++;
            cyc++;
        end
        chk("ni_beats", b, 4);
        chk("ni_cycles", cyc, 7);
        in_valid[1] = 1'b0; in_sop[1] = 1'b0; in_eop[1] = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ni_gap_valid", out_valid, 0);
        tick();
        chk("ni_p0_chan", out_channel, 0);
        chk("ni_p0_data", out_data, 64'hB0);
        chk("ni_p0_valid", out_valid, 1);
        tick();
        in_valid[0] = 1'b0; in_sop[0] = 1'b0; in_eop[0] = 1'b0;
        chk("ni_counts", pkt_count, {16'd2, 16'd2, 16'd3, 16'd3});

        // Mid-packet SOP on port 3
        in_valid[3] = 1'b1; in_sop[3] = 1'b1; in_data[3] = 64'hD1;
        tick();
        chk("ms_b1_chan", out_channel, 3);
        chk("ms_b1_data", out_data, 64'hD1);
        tick();
        in_data[3] = 64'hD2;
        #1;
        chk("ms_b2_data", out_data, 64'hD2);
        chk("ms_b2_err_before", err_sop, 0);
        tick();
        chk("ms_err_set", err_sop, 4'b1000);
        in_sop[3] = 1'b0; in_eop[3] = 1'b1; in_data[3] = 64'hD3;
        #1;
        chk("ms_b3_data", out_data, 64'hD3);
        chk("ms_b3_valid", out_valid, 1);
        tick();
        in_valid[3] = 1'b0; in_eop[3] = 1'b0;
        chk("ms_idle_busy", busy, 0);
        chk("ms_count", pkt_count[3], 3);
        chk("ms_err_sticky", err_sop, 4'b1000);

        // Counter wrap on port 0 (starts at 3)
        in_valid[0] = 1'b1; in_sop[0] = 1'b1; in_eop[0] = 1'b1; in_data[0] = 64'hE0;
        repeat (2) tick();
        chk("wr_count4", pkt_count[0], 4);
        repeat (2 * 65531) tick();
        chk("wr_count_max", pkt_count[0], 16'hFFFF);
        repeat (2) tick();
        chk("wr_count_wrap", pkt_count[0], 0);

        // Reset in the middle of a port-0 packet
        in_eop[0] = 1'b0;
        tick();
        tick();
        in_sop[0] = 1'b0;
        #1;
        chk("mr_busy_before", busy, 1);
        chk("mr_valid_before", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 0);
        chk("mr_chan", out_channel, 0);
        chk("mr_counts", pkt_count, 0);
        chk("mr_err", err_sop, 0);
        rst = 1'b0;
        in_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
